// File: rtl/qpsk_pkg.sv
// Constants and checksum shared by the QPSK framer and the demodulator's data-valid checker.
package qpsk_pkg;

    localparam logic [7:0]  DEFAULT_HEADER = 8'hcc;
    localparam int unsigned PAYLOAD_BITS   = 40;
    localparam int unsigned FRAME_BITS     = 56;
    localparam int unsigned SYMS_PER_FRAME = 28;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } tx_state_t;

    // 8-bit wrap-around sum of the payload bytes
    function automatic logic [7:0] byte_csum(input logic [PAYLOAD_BITS-1:0] payload);
        logic [7:0] sum;
        sum = '0;
        for (int unsigned i = 0; i < PAYLOAD_BITS / 8; i++) begin
            sum = sum + payload[8*i +: 8];
        end
        return sum;
    endfunction

endpackage

// File: rtl/qpsk_frame_tx_sym_timer.sv
// Sample counter for one symbol period, with a terminal-count strobe on its last cycle.
module sym_timer #(
    parameter int unsigned SAMPLE = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned   CW   = (SAMPLE > 1) ? $clog2(SAMPLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tc = enable && (count == LAST);

endmodule

// File: rtl/qpsk_frame_tx.sv
// QPSK transmit framer: {header, payload, checksum} sent MSB-first as I/Q pairs, SAMPLE cycles per symbol.
module qpsk_frame_tx
    import qpsk_pkg::*;
#(
    parameter logic [7:0]  HEADER = DEFAULT_HEADER,
    parameter int unsigned SAMPLE = 100,
    parameter int unsigned GAP    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PAYLOAD_BITS-1:0] para_in,
    input  logic                    para_valid,
    output logic                    para_ready,
    output logic                    ser_I,
    output logic                    ser_Q,
    output logic                    sym_flag,
    output logic                    tx_en,
    output logic                    frame_done
);

    localparam int unsigned   GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [4:0]    SYM_LAST = 5'(SYMS_PER_FRAME - 1);

    tx_state_t             state;
    logic [FRAME_BITS-1:0] shreg;
    logic [4:0]            sym_cnt;
    logic [GW-1:0]         gap_cnt;
    logic                  sym_end;

    // The timer free-runs through SEND into GAP, so the gap counts whole symbol periods.
    sym_timer #(
        .SAMPLE(SAMPLE)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (para_valid && para_ready),
        .enable(state != ST_IDLE),
        .tc    (sym_end)
    );

    // The shift register drains to zero by the end of a frame, keeping I/Q low outside SEND.
    assign ser_I = shreg[FRAME_BITS-1];
    assign ser_Q = shreg[FRAME_BITS-2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            sym_cnt    <= '0;
            gap_cnt    <= '0;
            para_ready <= 1'b1;
            sym_flag   <= 1'b0;
            tx_en      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sym_flag   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (para_valid) begin
                        state      <= ST_SEND;
                        shreg      <= {HEADER, para_in, byte_csum(para_in)};
                        sym_cnt    <= '0;
                        para_ready <= 1'b0;
                        tx_en      <= 1'b1;
                        sym_flag   <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (sym_end) begin
                        shreg <= shreg << 2;
                        if (sym_cnt == SYM_LAST) begin
                            tx_en      <= 1'b0;
                            frame_done <= 1'b1;
                            gap_cnt    <= '0;
                            if (GAP > 0) begin
                                state <= ST_GAP;
                            end else begin
                                state      <= ST_IDLE;
                                para_ready <= 1'b1;
                            end
                        end else begin
                            sym_cnt  <= sym_cnt + 1'b1;
                            sym_flag <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (sym_end) begin
                        if (gap_cnt == GAP_LAST) begin
                            state      <= ST_IDLE;
                            para_ready <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    para_ready <= 1'b1;
                    tx_en      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qpsk_frame_tx.sv
// Scoreboard bench for qpsk_frame_tx: one instance with GAP=2, one with GAP=0 for back-to-back frames.
module tb_qpsk_frame_tx;

    localparam int unsigned SAMPLE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        rst = 1'b1, para_valid = 1'b0;
    logic [39:0] para_in = '0;
    logic        para_ready, ser_I, ser_Q, sym_flag, tx_en, frame_done;

    logic        rst0 = 1'b1, para_valid0 = 1'b0;
    logic [39:0] para_in0 = '0;
    logic        para_ready0, ser_I0, ser_Q0, sym_flag0, tx_en0, frame_done0;

    logic [55:0] exp_q0[$];
    logic [55:0] exp_q1[$];

    qpsk_frame_tx #(.HEADER(8'hcc), .SAMPLE(SAMPLE), .GAP(2)) dut (
        .clk(clk), .rst(rst), .para_in(para_in), .para_valid(para_valid),
        .para_ready(para_ready), .ser_I(ser_I), .ser_Q(ser_Q), .sym_flag(sym_flag),
        .tx_en(tx_en), .frame_done(frame_done)
    );

    qpsk_frame_tx #(.HEADER(8'hcc), .SAMPLE(SAMPLE), .GAP(0)) dut0 (
        .clk(clk), .rst(rst0), .para_in(para_in0), .para_valid(para_valid0),
        .para_ready(para_ready0), .ser_I(ser_I0), .ser_Q(ser_Q0), .sym_flag(sym_flag0),
        .tx_en(tx_en0), .frame_done(frame_done0)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at cycle %0d", name, act, req, cyc);
        end
    endfunction

    // Monitor: rebuilds each frame from the symbol strobes, then acts as the ideal-channel receiver.
    logic [55:0] acc[2];
    int          nsym[2];
    int          last_sf[2];

    task automatic mon_step(input int id, input logic r, input logic sf, input logic si,
                            input logic sq, input logic te, input logic fd);
        logic [55:0] want;
        logic [7:0]  s;
        if (r) begin
            nsym[id] = 0;
            acc[id]  = '0;
            return;
        end
        if (!te) check("iq_zero_when_muted", {si, sq}, 2'b00);
        if (sf) begin
            check("tx_en_on_symbol", te, 1);
            if (nsym[id] > 0) check("symbol_spacing", cyc - last_sf[id], SAMPLE);
            acc[id]     = {acc[id][53:0], si, sq};
            nsym[id]    = nsym[id] + 1;
            last_sf[id] = cyc;
        end
        if (fd) begin
            check("tx_en_at_done", te, 0);
            check("symbols_per_frame", nsym[id], 28);
            if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
                check("unexpected_frame_done", fd, 0);
            end else begin
                if (id == 0) want = exp_q0.pop_front();
                else         want = exp_q1.pop_front();
                check("frame_bits", acc[id], want);
                s = '0;
                for (int b = 0; b < 5; b++) s = s + acc[id][8 + 8*b +: 8];
                check("loopback_payload", acc[id][47:8], want[47:8]);
                check("loopback_valid", (acc[id][55:48] == 8'hcc) && (acc[id][7:0] == s), 1);
            end
            nsym[id] = 0;
        end
    endtask

    always @(negedge clk) mon_step(0, rst0, sym_flag0, ser_I0, ser_Q0, tx_en0, frame_done0);
    always @(negedge clk) mon_step(1, rst, sym_flag, ser_I, ser_Q, tx_en, frame_done);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int id, input int which);
        if (id == 0) return (which == 0) ? frame_done0 : para_ready0;
        return (which == 0) ? frame_done : para_ready;
    endfunction

    // which: 0 = frame_done, 1 = para_ready; returns the cycle it was first seen, -1 on timeout
    task automatic wait_sig(input int id, input int which, input int limit, output int at);
        at = -1;
        for (int n = 0; n < limit; n++) begin
            tick();
            if (sig(id, which)) begin
                at = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_timeout: dut %0d signal %0d not seen within %0d cycles", id, which, limit);
    endtask

    task automatic offer(input logic [39:0] p, output int e);
        para_in    = p;
        para_valid = 1'b1;
        e          = cyc + 1;
        tick();
        para_valid = 1'b0;
        para_in    = 40'h5a5a0f0f33;
    endtask

    initial begin
        fork
            begin : main_dut
                int e, at;
                logic [7:0] tail;
                repeat (3) tick();
                check("rst_para_ready", para_ready, 1);
                check("rst_ser_I", ser_I, 0);
                check("rst_ser_Q", ser_Q, 0);
                check("rst_sym_flag", sym_flag, 0);
                check("rst_tx_en", tx_en, 0);
                check("rst_frame_done", frame_done, 0);
                rst = 1'b0;
                tick();

                exp_q1.push_back(56'hcc_123456789a_ae);
                offer(40'h123456789a, e);
                check("first_tx_en", tx_en, 1);
                check("first_sym_flag", sym_flag, 1);
                check("first_para_ready", para_ready, 0);
                check("sym0_iq", {ser_I, ser_Q}, 2'b11);
                tick();
                check("sym_flag_single", sym_flag, 0);
                repeat (3) tick();
                check("sym1_iq", {ser_I, ser_Q}, 2'b00);
                check("sym1_flag", sym_flag, 1);
                wait_sig(1, 0, 300, at);
                check("done_cycle", at - e, 112);
                wait_sig(1, 1, 300, at);
                check("ready_return_cycle", at - e, 120);

                exp_q1.push_back(56'hcc_ffffffffff_fb);
                offer(40'hffffffffff, e);
                repeat (20) tick();
                para_in    = 40'hdeadbeef01;
                para_valid = 1'b1;
                tick();
                check("ready_low_while_sending", para_ready, 0);
                para_valid = 1'b0;
                tail = 8'b11111011;
                for (int k = 24; k < 28; k++) begin
                    while (cyc < e + 4*k) tick();
                    check("wrap_csum_tail", {ser_I, ser_Q}, tail[7 - 2*(k-24) -: 2]);
                end
                wait_sig(1, 0, 300, at);
                check("done_cycle_ff", at - e, 112);
                wait_sig(1, 1, 300, at);

                offer(40'ha5a5a5a5a5, e);
                while (cyc < e + 41) tick();
                rst = 1'b1;
                tick();
                check("abort_ser_I", ser_I, 0);
                check("abort_ser_Q", ser_Q, 0);
                check("abort_tx_en", tx_en, 0);
                check("abort_para_ready", para_ready, 1);
                check("abort_frame_done", frame_done, 0);
                check("abort_sym_flag", sym_flag, 0);
                rst = 1'b0;

                exp_q1.push_back(56'hcc_8040201008_f8);
                offer(40'h8040201008, e);
                check("after_abort_sym0", {ser_I, ser_Q}, 2'b11);
                wait_sig(1, 0, 300, at);
                check("done_cycle_after_abort", at - e, 112);
                wait_sig(1, 1, 300, at);

                exp_q1.push_back(56'hcc_0102030405_0f);
                offer(40'h0102030405, e);
                wait_sig(1, 0, 300, at);
                wait_sig(1, 1, 300, at);
            end
            begin : gapless_dut
                int e0, at;
                para_in0    = '0;
                para_valid0 = 1'b1;
                repeat (3) tick();
                repeat (3) exp_q0.push_back(56'hcc_0000000000_00);
                e0   = cyc + 1;
                rst0 = 1'b0;
                tick();
                check("b2b_first_tx_en", tx_en0, 1);
                for (int f = 1; f <= 3; f++) begin
                    wait_sig(0, 0, 300, at);
                    check("b2b_done_cycle", at - e0, 113*f - 1);
                    check("b2b_gap_tx_en_low", tx_en0, 0);
                    tick();
                    if (f < 3) begin
                        check("b2b_restart_tx_en", tx_en0, 1);
                        check("b2b_restart_sym_flag", sym_flag0, 1);
                    end else begin
                        check("b2b_stopped_tx_en", tx_en0, 0);
                    end
                    if (f == 2) para_valid0 = 1'b0;
                end
            end
        join
        repeat (4) tick();
        check("scoreboard_drained", exp_q0.size() + exp_q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qpsk_frame_tx.md
# qpsk_frame_tx

Transmit-side framer and symbol mapper for the QPSK link. It accepts a 40-bit parallel payload through a valid/ready handshake and builds a 56-bit frame of header, payload and checksum. It then emits the frame MSB-first as I/Q bit pairs, one pair per symbol, each symbol held for SAMPLE sample-clock cycles. It sits between the payload source and the modulator's carrier multipliers, and produces exactly the frame format the demodulator's data-valid checker expects.

## Interface
- HEADER, 8'hcc, frame header byte, sent first
- SAMPLE, 100, sample-clock cycles per symbol (must be ≥ 2)
- GAP, 4, idle symbols inserted after each frame (0 allowed)

Ports:
- clk  in  1  sample clock (500 kHz in system)
- rst  in  1  reset, synchronous, active-high
- para_in  in  40  payload, sampled on acceptance
- para_valid  in  1  payload offered
- para_ready  out  1  block can accept; high only in IDLE
- ser_I  out  1  current symbol's I bit (even frame bit)
- ser_Q  out  1  current symbol's Q bit (odd frame bit)
- sym_flag  out  1  one-cycle pulse on the first cycle of each symbol
- tx_en  out  1  high while frame symbols are on ser_I/ser_Q (modulator unmutes carrier)
- frame_done  out  1  one-cycle pulse after the last symbol ends

## Operation
- Frame, 56 bits, MSB first: {HEADER, para_in[39:0], CSUM}. CSUM = (para_in[39:32]+[31:24]+[23:16]+[15:8]+[7:0]) mod 256, computed in 8-bit wrap-around arithmetic.
- Symbol k (0..27): ser_I = frame bit 55−2k, ser_Q = frame bit 54−2k.
- States:
  - IDLE: para_ready=1. Go to SEND on para_valid & para_ready.
  - SEND: 28 symbols. Go to GAP after the last symbol when GAP>0, otherwise to IDLE.
  - GAP: GAP×SAMPLE cycles. Return to IDLE.
- Acceptance loads a 56-bit shift register and clears the sample counter (0..SAMPLE−1) and the symbol counter (0..27). When sample counter = SAMPLE−1, the shift register shifts left by 2 and the symbol counter increments.
- In IDLE and GAP: ser_I=0, ser_Q=0, tx_en=0, sym_flag=0.
- para_valid while not IDLE is ignored. para_in is not required stable after acceptance.
- Reset values, all outputs: para_ready=1 (IDLE), ser_I=0, ser_Q=0, sym_flag=0, tx_en=0, frame_done=0.

## Timing
- Acceptance at edge t. From cycle t+1: state SEND, para_ready=0, tx_en=1, symbol 0 on ser_I/ser_Q, sym_flag=1 for that cycle only.
- Symbol k occupies cycles t+1+k·SAMPLE … t+(k+1)·SAMPLE. sym_flag pulses on the first of those cycles.
- Cycle t+28·SAMPLE+1: tx_en=0, frame_done=1 for one cycle, and state becomes GAP (or IDLE if GAP=0).
- IDLE re-entered at t+(28+GAP)·SAMPLE+1, with para_ready=1 that cycle. The minimum frame-to-frame period is (28+GAP)·SAMPLE+1 cycles.
- para_valid held continuously: the next payload is accepted at the first IDLE edge. No bubble beyond that one cycle.
- rst asserted mid-frame or mid-gap: all outputs take their reset values at the next edge. The frame is aborted, with no frame_done and no partial symbol completion.
- Registered outputs only. No combinational path from para_valid to para_ready.

## Structure
- Shared package/include qpsk_pkg: default HEADER (8'hcc), PAYLOAD_BITS=40, FRAME_BITS=56, SYMS_PER_FRAME=28, and a byte-checksum function. The demodulator's data-valid checker uses the same constants and function.
- Sub-module sym_timer: the sample counter plus its terminal-count strobe, parameterised by SAMPLE. Reusable for gap timing: the gap counts GAP symbol-ends.
- Counter widths: $clog2(SAMPLE) for the sample counter, 5 bits for the symbol counter, $clog2(GAP+1) for the gap count.

## Test plan
- SAMPLE=4, GAP=2, payload 40'h123456789A.
  - Frame: CC 12 34 56 78 9A AE.
  - First two symbols (I,Q) = (1,1) then (0,0).
  - 28 sym_flag pulses, 4 cycles apart.
  - frame_done at t+113.
  - para_ready returns high at t+121.
- Payload 40'hFFFFFFFFFF: CSUM = 8'hFB (wrap-around). The last four symbols are (1,1),(1,1),(1,0),(1,1).
- Payload 0, GAP=0, para_valid held high: back-to-back frames are accepted every 113 cycles, and tx_en is low for exactly one cycle between frames.
- para_valid pulsed during SEND with a different payload: it is ignored, the frame in progress is unchanged, and para_ready stays 0.
- rst asserted at symbol 10: the next cycle shows ser_I/ser_Q/tx_en=0 and para_ready=1, with no frame_done. A new payload accepted after rst is released transmits cleanly from the header.
- Loopback: the bench models the ideal channel and feeds the demodulator chain. The recovered 40-bit output equals the transmitted payload and the valid flag asserts for every frame.
